// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - fetch/LSU arbiter for one SRAM-like port with in-order response tag FIFO; ARB_RR_EN selects round-robin priority
module sram_bus_arbiter #(
  parameter int MAX_OUTS = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [31:0]       mem_rdata
);
  localparam int PTR_W = $clog2(MAX_OUTS);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD_INST = 2'd1, HOLD_DATA = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [MAX_OUTS-1:0] tag_q;

  logic room;
  logic pick_data;
  logic grant_data;
  logic push;
  logic pop;
  logic head;

  assign room = (count_q < CNT_W'(MAX_OUTS));
  assign push = mem_req & mem_addr_ok;
  assign pop  = mem_data_ok & (count_q != '0);
  assign head = tag_q[rd_ptr_q];

`ifdef ARB_RR_EN
  logic rr_q;

  // Idle-state winner: rr_q names the master that wins a tie (0=inst, 1=data)
  always_comb begin
    if (rr_q) pick_data = data_req | ~inst_req;
    else      pick_data = data_req & ~inst_req;
  end

  // After every accepted request the other master gets priority
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   rr_q <= 1'b0;
    else if (push) rr_q <= ~grant_data;
  end
`else
  // Fixed priority: the LSU always beats fetch in IDLE
  always_comb pick_data = data_req;
`endif

  // Grant FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A request shown to memory but not taken locks the grant until it is accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_req && !mem_addr_ok) state_d = pick_data ? HOLD_DATA : HOLD_INST;
      end
      HOLD_INST, HOLD_DATA: begin
        if (push) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request path and response routing, all combinational; mem fields read 0 when no request
  always_comb begin
    grant_data   = (state_q == HOLD_DATA) || ((state_q == IDLE) && pick_data);
    mem_req      = resetn & room & ((state_q != IDLE) | inst_req | data_req);
    mem_wr       = 1'b0;
    mem_wstrb    = 4'b0;
    mem_addr     = '0;
    mem_wdata    = 32'b0;
    if (mem_req) begin
      if (grant_data) begin
        mem_wr    = data_wr;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_addr  = inst_addr;
      end
    end
    inst_addr_ok = push & ~grant_data;
    data_addr_ok = push & grant_data;
    inst_data_ok = pop & ~head;
    data_data_ok = pop & head;
    rdata        = mem_rdata;
  end

  // Occupancy: a simultaneous push and pop cancel out
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // Tag FIFO storage and wrap-around pointers (MAX_OUTS is a power of two)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= grant_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - self-checking bench for sram_bus_arbiter (directed scenarios plus randomized model run)
module tb_sram_bus_arbiter;
  localparam int MAX_OUTS = 4;
  localparam int ADDR_W   = 32;

  logic              clk = 1'b0;
  logic              resetn;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic              data_req;
  logic              data_wr;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       rdata;
  logic              mem_req;
  logic              mem_wr;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [31:0]       mem_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  sram_bus_arbiter #(.MAX_OUTS(MAX_OUTS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .rdata(rdata), .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    inst_req = 0; inst_addr = '0; data_req = 0; data_wr = 0; data_wstrb = '0;
    data_addr = '0; data_wdata = '0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    resetn = 0;
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 0; inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    inst_addr = 32'h1C00_0000; data_addr = 32'h1000;
    #1;
    tests_run++;
    if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    tests_run++;
    if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin
      tests_failed++; $display("FAIL reset_oks got %b want 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
    end
    @(negedge clk);
    clear_inputs(); mem_rdata = 32'h5555_AAAA;
    resetn = 1;
    #1;
    tests_run++;
    if ({mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== '0)
    begin tests_failed++; $display("FAIL idle_outputs_zero got mem_req=%b mem_addr=%h want all 0", mem_req, mem_addr); end
    tests_run++;
    if (rdata !== 32'h5555_AAAA) begin tests_failed++; $display("FAIL rdata_follow got %h want 5555aaaa", rdata); end
    @(negedge clk);
    mem_data_ok = 1; inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1;
    #1;
    tests_run++;
    if ({inst_addr_ok, inst_data_ok, mem_addr} !== {1'b1, 1'b0, 32'h1C00_0000}) begin
      tests_failed++; $display("FAIL first_grant got aok=%b dok=%b addr=%h want 1 0 1c000000", inst_addr_ok, inst_data_ok, mem_addr);
    end
  endtask

`ifdef ARB_RR_EN
  task automatic test_priority();
    do_reset();
    inst_req = 1; inst_addr = 32'h1C00_0000; data_req = 1; data_addr = 32'h1000;
    data_wr = 1; data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF; mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if ({inst_addr_ok, data_addr_ok} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        tests_failed++; $display("FAIL rr_alternate[%0d] got inst=%b data=%b", i, inst_addr_ok, data_addr_ok);
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask
`else
  task automatic test_priority();
    do_reset();
    inst_req = 1; inst_addr = 32'h1C00_0000; data_req = 1; data_addr = 32'h1000;
    data_wr = 1; data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF; mem_addr_ok = 1;
    #1;
    tests_run++;
    if ({data_addr_ok, inst_addr_ok, mem_addr, mem_wr, mem_wstrb, mem_wdata} !== {2'b10, 32'h1000, 1'b1, 4'hF, 32'hDEAD_BEEF})
    begin tests_failed++; $display("FAIL prio_data_first got daok=%b iaok=%b addr=%h wr=%b", data_addr_ok, inst_addr_ok, mem_addr, mem_wr); end
    @(negedge clk);
    data_req = 0;
    #1;
    tests_run++;
    if ({inst_addr_ok, data_addr_ok, mem_addr, mem_wr, mem_wstrb, mem_wdata} !== {2'b10, 32'h1C00_0000, 1'b0, 4'h0, 32'h0})
    begin tests_failed++; $display("FAIL prio_inst_second got iaok=%b addr=%h wr=%b wdata=%h", inst_addr_ok, mem_addr, mem_wr, mem_wdata); end
    @(negedge clk);
    clear_inputs();
  endtask
`endif

  task automatic test_hold();
    do_reset();
    inst_req = 1; inst_addr = 32'h1C00_0000;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin data_req = 1; data_addr = 32'h2000; data_wr = 1; data_wstrb = 4'h3; data_wdata = 32'h1234; end
      #1;
      tests_run++;
      if ({mem_req, mem_addr, inst_addr_ok, data_addr_ok} !== {1'b1, 32'h1C00_0000, 2'b00}) begin
        tests_failed++; $display("FAIL hold_cycle%0d got req=%b addr=%h aok=%b%b", i, mem_req, mem_addr, inst_addr_ok, data_addr_ok);
      end
      @(negedge clk);
    end
    mem_addr_ok = 1;
    #1;
    tests_run++;
    if ({inst_addr_ok, data_addr_ok, mem_addr} !== {2'b10, 32'h1C00_0000}) begin
      tests_failed++; $display("FAIL hold_accept got aok=%b%b addr=%h want 10 1c000000", inst_addr_ok, data_addr_ok, mem_addr);
    end
    @(negedge clk);
    inst_req = 0;
    #1;
    tests_run++;
    if ({data_addr_ok, mem_addr, mem_wstrb} !== {1'b1, 32'h2000, 4'h3}) begin
      tests_failed++; $display("FAIL hold_then_data got daok=%b addr=%h strb=%h", data_addr_ok, mem_addr, mem_wstrb);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_full();
    do_reset();
    inst_req = 1; inst_addr = 32'h1C00_0040; mem_addr_ok = 1;
    for (int i = 0; i < MAX_OUTS; i++) begin
      #1;
      tests_run++;
      if (inst_addr_ok !== 1'b1) begin tests_failed++; $display("FAIL full_fill[%0d] got %b want 1", i, inst_addr_ok); end
      @(negedge clk);
    end
    #1;
    tests_run++;
    if ({mem_req, inst_addr_ok} !== 2'b00) begin tests_failed++; $display("FAIL full_blocks got req=%b aok=%b want 00", mem_req, inst_addr_ok); end
    @(negedge clk);
    mem_data_ok = 1;
    #1;
    tests_run++;
    if ({mem_req, inst_data_ok} !== 2'b01) begin tests_failed++; $display("FAIL full_pop got req=%b dok=%b want 01", mem_req, inst_data_ok); end
    @(negedge clk);
    mem_data_ok = 0;
    #1;
    tests_run++;
    if ({mem_req, inst_addr_ok} !== 2'b11) begin tests_failed++; $display("FAIL full_refill got req=%b aok=%b want 11", mem_req, inst_addr_ok); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_order();
    logic [1:0]  exp_ok [4];
    logic [31:0] rd     [4];
    exp_ok[0] = 2'b10; exp_ok[1] = 2'b01; exp_ok[2] = 2'b10; exp_ok[3] = 2'b00;
    rd[0] = 32'hA; rd[1] = 32'hB; rd[2] = 32'hC; rd[3] = 32'hD;
    do_reset();
    mem_addr_ok = 1;
    inst_req = 1; inst_addr = 32'h100;
    @(negedge clk);
    inst_req = 0; data_req = 1; data_addr = 32'h200;
    @(negedge clk);
    data_req = 0; inst_req = 1; inst_addr = 32'h104;
    @(negedge clk);
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = rd[i];
      #1;
      tests_run++;
      if ({inst_data_ok, data_data_ok, rdata} !== {exp_ok[i], rd[i]}) begin
        tests_failed++; $display("FAIL order[%0d] got ok=%b%b rdata=%h want %b %h", i, inst_data_ok, data_data_ok, rdata, exp_ok[i], rd[i]);
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    bit i_act, d_act, prio, mreq, push, pop, g;
    int locked;
    bit q[$];
    logic [105:0] got, exp;
    logic [ADDR_W-1:0] e_addr;
    do_reset();
    i_act = 0; d_act = 0; prio = 0; locked = -1; q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!i_act && $urandom_range(0, 1) == 1) begin i_act = 1; inst_addr = $urandom; end
      if (!d_act && $urandom_range(0, 1) == 1) begin
        d_act = 1; data_addr = $urandom; data_wr = 1'($urandom); data_wstrb = 4'($urandom); data_wdata = $urandom;
      end
      inst_req = i_act; data_req = d_act;
      mem_addr_ok = ($urandom_range(0, 2) != 0);
      mem_data_ok = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      #1;
      mreq = (q.size() < MAX_OUTS) && (locked >= 0 || i_act || d_act);
`ifdef ARB_RR_EN
      if (locked >= 0) g = locked[0];
      else if (prio)   g = d_act || !i_act;
      else             g = !i_act && d_act;
`else
      if (locked >= 0) g = locked[0];
      else             g = d_act;
`endif
      push = mreq && mem_addr_ok;
      pop = mem_data_ok && (q.size() != 0);
      e_addr = !mreq ? '0 : (g ? data_addr : inst_addr);
      exp = {mreq, push && !g, push && g, pop && !q[0], pop && q[0], e_addr,
             mreq && g && data_wr, (mreq && g) ? data_wstrb : 4'h0, (mreq && g) ? data_wdata : 32'h0, mem_rdata};
      got = {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_addr,
             mem_wr, mem_wstrb, mem_wdata, rdata};
      tests_run++;
      if (got !== exp) begin
        tests_failed++; $display("FAIL random[%0d] got %h want %h", cyc, got, exp);
      end
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(g);
        if (g) d_act = 0; else i_act = 0;
        locked = -1;
        prio = !g;
      end else if (mreq) begin
        locked = g ? 1 : 0;
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    resetn = 0;
    test_reset();
    test_priority();
    test_hold();
    test_full();
    test_order();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
